// File: rtl/debounce_scan.sv
// rtl/debounce_scan.sv - time-multiplexed debounce controller with a shared compare/increment datapath
module debounce_scan #(
  parameter int CHANNELS = 6,
  parameter int BITS     = 3,
  parameter int PRESCALE = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [CHANNELS-1:0]         buttons,
  output logic [CHANNELS-1:0]         debounced,
  output logic [CHANNELS-1:0]         changed,
  output logic [$clog2(CHANNELS)-1:0] scan_index,
  output logic                        scan_done,
  output logic                        overrun
);

  localparam int IW = $clog2(CHANNELS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]   PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]   LAST_CHAN = IW'(CHANNELS - 1);
  localparam logic [BITS-1:0] CNT_MAX   = {BITS{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Synchronizer stages; sync_q is the value the scanner compares against.
  logic [CHANNELS-1:0] meta_q;
  logic [CHANNELS-1:0] sync_q;

  // Prescaler and sweep scheduler state.
  logic [PW-1:0] prescale_q;
  logic          tick;
  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] index_d;
  logic          done_d;
  logic          overrun_d;

  // Per-channel register bank: stability counter and last observed level.
  logic [BITS-1:0]     cnt_q [CHANNELS];
  logic [CHANNELS-1:0] prev_q;

  // Shared datapath signals for the channel being visited.
  logic                visit;
  logic                sel_sync;
  logic                sel_prev;
  logic                sel_deb;
  logic [BITS-1:0]     sel_cnt;
  logic [BITS-1:0]     nxt_cnt;
  logic                nxt_prev;
  logic                nxt_deb;
  logic                commit;
  logic [CHANNELS-1:0] changed_d;

  // Two-flop synchronizer on every raw input, independent of the scanner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= buttons;
      sync_q <= meta_q;
    end
  end

  // Prescaler: free-running modulo counter that freezes while enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
    end else if (enable) begin
      if (prescale_q == PRE_MAX) begin
        prescale_q <= '0;
      end else begin
        prescale_q <= prescale_q + PW'(1);
      end
    end
  end

  assign tick = enable && (prescale_q == PRE_MAX);

  // Scheduler state register, visit pointer, sweep-done pulse and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      scan_index <= '0;
      scan_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_index <= index_d;
      scan_done  <= done_d;
      overrun    <= overrun_d;
    end
  end

  // Scheduler next state: a tick starts a sweep, a tick inside a sweep is dropped and flagged.
  always_comb begin
    state_d   = state_q;
    index_d   = scan_index;
    done_d    = 1'b0;
    overrun_d = overrun;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          index_d = '0;
        end
      end
      SCAN: begin
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (scan_index == LAST_CHAN) begin
          state_d = IDLE;
          index_d = '0;
          done_d  = 1'b1;
        end else begin
          index_d = scan_index + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  assign visit    = (state_q == SCAN);
  assign sel_sync = sync_q[scan_index];
  assign sel_prev = prev_q[scan_index];
  assign sel_deb  = debounced[scan_index];
  assign sel_cnt  = cnt_q[scan_index];

  // Shared compare/increment: a level change restarts the count, a full count commits the level.
  always_comb begin
    nxt_cnt  = sel_cnt;
    nxt_prev = sel_prev;
    nxt_deb  = sel_deb;
    commit   = 1'b0;
    if (sel_sync != sel_prev) begin
      nxt_cnt  = '0;
      nxt_prev = sel_sync;
    end else if (sel_cnt != CNT_MAX) begin
      nxt_cnt = sel_cnt + BITS'(1);
    end else if (sel_deb != sel_prev) begin
      nxt_deb = sel_prev;
      commit  = 1'b1;
    end
  end

  // One-hot change pulse for the channel that commits in this cycle; all other bits stay low.
  always_comb begin
    changed_d = '0;
    if (visit && commit) begin
      changed_d[scan_index] = 1'b1;
    end
  end

  // Register bank write-back: only the visited channel is updated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      prev_q    <= '0;
      debounced <= '0;
      changed   <= '0;
    end else begin
      changed <= changed_d;
      if (visit) begin
        cnt_q[scan_index]     <= nxt_cnt;
        prev_q[scan_index]    <= nxt_prev;
        debounced[scan_index] <= nxt_deb;
      end
    end
  end

endmodule

// File: doc/debounce_scan.md
Name: debounce_scan

Overview:
- Time-multiplexed debounce controller for the rgb_mixer front end.
- One scheduler sweeps all CHANNELS raw inputs (encoder A/B lines and push buttons) round-robin, one channel per clock, at a prescaled sweep rate.
- Per-channel stability counters are stored in a register bank; the compare/increment datapath is shared.
- Produces a debounced level and a one-cycle change pulse per channel for the encoder decoders.

Parameters:
- CHANNELS, 6, number of raw inputs scanned (2..16).
- BITS, 3, stability counter width; a channel commits after 2^BITS consecutive equal sweeps.
- PRESCALE, 16, clock cycles between sweep ticks; must exceed CHANNELS.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  prescaler run enable
- buttons  input  CHANNELS  raw asynchronous inputs
- debounced  output  CHANNELS  debounced levels
- changed  output  CHANNELS  one-cycle pulse on a bit whose debounced level updated
- scan_index  output  $clog2(CHANNELS)  channel visited in the current cycle
- scan_done  output  1  one-cycle pulse after the last channel of a sweep
- overrun  output  1  sticky: a tick arrived while a sweep was in progress

Behaviour:
- Reset (reset=0, asynchronous): clears synchronizers, prescaler, state (IDLE), scan_index, all counters, prev bits, debounced, changed, scan_done and overrun to 0.
- Synchronizer: two flops per channel, always running. sync[i] lags buttons[i] by 2 cycles.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1 and wraps to 0.
  - Holds its value while enable=0.
  - tick = enable && prescaler==PRESCALE-1.
- FSM, IDLE:
  - tick -> SCAN, scan_index<=0.
- FSM, SCAN:
  - Visits channel scan_index each cycle, then increments scan_index.
  - At scan_index==CHANNELS-1 -> IDLE, scan_index<=0.
  - A sweep takes exactly CHANNELS cycles.
- Visit of channel i, evaluated in priority order:
  1. sync[i]!=prev[i]: cnt[i]<=0, prev[i]<=sync[i].
  2. Else cnt[i]!=2^BITS-1: cnt[i]<=cnt[i]+1.
  3. Else debounced[i]!=prev[i]: debounced[i]<=prev[i], changed[i] asserted for the following cycle only.
  4. Else no change.
- Unvisited channels: state untouched.
- changed: all bits other than those set by a visit are 0 every cycle.
- scan_done: registered, high for 1 cycle, the cycle after the CHANNELS-1 visit.
- Tick during SCAN:
  - Sweep continues unchanged; the tick is dropped.
  - overrun<=1, cleared only by reset.
  - Cannot happen when PRESCALE>CHANNELS and enable stays constant.
- enable deasserted mid-sweep: the current sweep completes; no new tick.
- Commit latency: an input stable from sweep k (first mismatch seen at sweep k) commits in sweep k+2^BITS, with changed pulsing one cycle after that channel's visit.
- Any mismatch before commit restarts the count. Pulses shorter than 2^BITS sweeps never reach debounced.
- Reset asserted mid-sweep: immediate clear to reset values. The first tick after release is at cycle PRESCALE-1.
- Several channels committing in one sweep: each pulses on its own cycle, never merged.

Test Plan (CHANNELS=4, BITS=2, PRESCALE=8 unless stated):
- buttons=4'b0001 held from reset release, enable=1 -> debounced[0] rises in sweep 5 (1 mismatch sweep + 3 count sweeps + commit). changed[0] pulses exactly once, the cycle after the ch0 visit. Other bits stay 0.
- Glitch: buttons[1] high for 2 sweeps then low -> debounced[1] stays 0 and changed stays 0 throughout.
- buttons=4'b1111 simultaneously -> debounced bits set in sweep 5 with changed pulses on 4 consecutive cycles (bit0..bit3). scan_done pulses once per 8 cycles.
- After all four bits are high, drive buttons to 0 -> each bit falls 5 sweeps later with one changed pulse.
- enable=0 for 20 cycles mid-sweep -> current sweep finishes with one scan_done, then no scan_index activity. The prescaler resumes from its held value when enable returns.
- Overrun: PRESCALE=4 -> overrun sets at the first tick during SCAN and stays 1. Reset clears it.
- Reset pulse in the middle of a sweep with debounced=4'b1010 -> all outputs 0 immediately. Re-debounce of held inputs completes again in sweep 5 after release.
